lsu_mem_master: RTL and testbench

//  Load/store initiator between the RV32I datapath and the word-addressed data memory (data_mem).

---
 rtl/lsu_mem_master_if.sv | 27 ++
 rtl/lsu_mem_master.sv | 130 +++++++++++++
 tb/tb_lsu_mem_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory port bundle for lsu_mem_master.
// master = the LSU itself; slave = core + memory side driving it.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_Address;
  logic [31:0] mem_RD;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_WD, mem_Address
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_WD, mem_Address
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator onto a word-addressed memory port (RMW for SB/SH).
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses raise resp_err.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 1000
) (
  input  logic              clk,
  input  logic              reset,
  lsu_mem_master_if.master  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state, state_nxt;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] wd_q;
  logic [31:0] addr_out_q;

  logic f3_bad, range_bad, mis_bad, req_err;
  logic [2:0] f3;
  assign f3 = bus.req_funct3;

  assign f3_bad    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                     (bus.req_we && f3[2]);
  assign range_bad = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS;
`ifdef MISALIGN_TRAP_EN
  assign mis_bad   = ((f3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((f3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign mis_bad   = 1'b0;
`endif
  assign req_err   = f3_bad || range_bad || mis_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (req_err)                          state_nxt = RESP;
        else if (bus.req_we && f3 == 3'b010)  state_nxt = WR;
        else                                  state_nxt = RD;
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load extraction from the word presented in RD
  logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes, merged;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign rd_lanes = bus.mem_RD;
  assign ld_byte  = rd_lanes[lane_q];
  assign ld_half  = lane_q[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];

  always_comb begin
    load_val = bus.mem_RD;
    case (f3_q)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {24'h0, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = bus.mem_RD;
    endcase
  end

  // Store merge: replicate store data across lanes, keep unaddressed bytes
  assign wr_lanes = (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic lane_en;
    assign lane_en   = (f3_q[1:0] == 2'b00) ? (lane_q == LANE) : (lane_q[1] == LANE[1]);
    assign merged[i] = lane_en ? wr_lanes[i] : rd_lanes[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      wd_q       <= 32'h0;
      addr_out_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          f3_q    <= f3;
          lane_q  <= bus.req_addr[1:0];
          wdata_q <= bus.req_wdata[15:0];
          err_q   <= req_err;
          rdata_q <= 32'h0;
          if (!req_err) begin
            addr_out_q <= {bus.req_addr[31:2], 2'b00};
            wd_q       <= bus.req_wdata;
          end
        end
        RD: begin
          if (!we_q) rdata_q <= load_val;
          else       wd_q    <= merged;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_err    = err_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.mem_WE      = (state == WR);
  assign bus.mem_WD      = wd_q;
  assign bus.mem_Address = addr_out_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed spec scenarios plus
// randomized ops against a word-array reference model.
module tb_lsu_mem_master;
  localparam int W = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();
  lsu_mem_master #(.MEM_WORDS(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // data memory behind the port
  logic [31:0] mem [0:W-1];
  logic [31:0] ref_mem [0:W-1];
  logic init_done = 1'b0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < W; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (bus.mem_WE && int'(bus.mem_Address[31:2]) < W) begin
      mem[int'(bus.mem_Address[31:2])] <= bus.mem_WD;
    end
  end

  assign bus.mem_RD = (int'(bus.mem_Address[31:2]) < W) ? mem[int'(bus.mem_Address[31:2])] : 32'h0;

  int cyc = 0;
  int acc_q[$];
  int we_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    if (bus.mem_WE) we_cnt <= we_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic exp_err(logic we, logic [2:0] f3, logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if (a / 4 >= W) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 2 && (a % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] word, logic [2:0] f3, logic [31:0] a);
    logic [31:0] b, h;
    b = (word >> ((a % 4) * 8)) & 32'hFF;
    h = (word >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] exp_store(logic [31:0] word, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic [31:0] m;
    int sh;
    if (f3 == 0)      begin sh = (a % 4) * 8;         m = 32'hFF << sh;   end
    else if (f3 == 1) begin sh = ((a % 4) / 2) * 16;  m = 32'hFFFF << sh; end
    else              begin sh = 0;                   m = 32'hFFFFFFFF;   end
    return (word & ~m) | ((wd << sh) & m);
  endfunction

  function automatic int exp_lat(logic we, logic [2:0] f3, logic err);
    if (err) return 1;
    if (!we || f3 == 2) return 2;
    return 3;
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int t = 0;
    @(negedge clk);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    rd = 32'h0; er = 1'b0; lat = -1;
    if (!bus.req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!bus.resp_valid) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", bus.resp_valid);
      lat = -1;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_chk++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    n_chk++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    n_chk++; if (bus.mem_WE !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.mem_WE); end
    n_chk++; if (bus.mem_WD !== 32'h0) begin n_fail++; $display("FAIL rst_wd: got %h want 0", bus.mem_WD); end
    n_chk++; if (bus.mem_Address !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.mem_Address); end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
    ref_mem[4] = 32'hDEADBEEF;
    n_chk++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL sw_lat: lat=%0d err=%b want 2/0", lat, er); end
    n_chk++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_word: got %h want deadbeef", mem[4]); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (rd !== 32'hDEADBEEF || lat !== 2) begin n_fail++; $display("FAIL lw_data: got %h lat=%0d want deadbeef/2", rd, lat); end
  endtask

  task automatic test_sub_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 3'b010, 32'h4, 32'h11223344, 1'b0, rd, er, lat);
    do_req(1'b1, 3'b000, 32'h6, 32'h000000AA, 1'b0, rd, er, lat);
    ref_mem[1] = 32'h11AA3344;
    n_chk++; if (lat !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL sb_lat: lat=%0d err=%b want 3/0", lat, er); end
    n_chk++; if (mem[1] !== 32'h11AA3344) begin n_fail++; $display("FAIL sb_word: got %h want 11aa3344", mem[1]); end
    do_req(1'b0, 3'b000, 32'h6, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (rd !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb: got %h want ffffffaa", rd); end
    do_req(1'b0, 3'b100, 32'h6, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL lbu: got %h want 000000aa", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 3'b010, 32'h8, 32'h80017FFF, 1'b0, rd, er, lat);
    do_req(1'b0, 3'b001, 32'hA, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h want ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h8, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (rd !== 32'h00007FFF) begin n_fail++; $display("FAIL lhu: got %h want 00007fff", rd); end
    do_req(1'b1, 3'b001, 32'hA, 32'hCAFE1234, 1'b0, rd, er, lat);
    ref_mem[2] = 32'h12347FFF;
    n_chk++; if (mem[2] !== 32'h12347FFF || lat !== 3) begin n_fail++; $display("FAIL sh_word: got %h lat=%0d want 12347fff/3", mem[2], lat); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; int we0;
    we0 = we_cnt;
    do_req(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 1'b0, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_sbu: err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); end
    do_req(1'b0, 3'b010, 32'd4000, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_range: err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); end
    do_req(1'b1, 3'b010, 32'd4000, 32'h12345678, 1'b0, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL err_range_sw: err=%b lat=%0d want 1/1", er, lat); end
    do_req(1'b0, 3'b011, 32'h0, 32'h0, 1'b0, rd, er, lat);
    n_chk++; if (er !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL err_f3: err=%b lat=%0d want 1/1", er, lat); end
    n_chk++; if (we_cnt !== we0) begin n_fail++; $display("FAIL err_nowrite: we cycles=%0d want 0", we_cnt - we0); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 3'b010, 32'h13, 32'h0, 1'b0, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
    n_chk++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_lw: err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); end
`else
    n_chk++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_lw: err=%b rd=%h want 0/deadbeef", er, rd); end
`endif
    do_req(1'b0, 3'b001, 32'h9, 32'h0, 1'b0, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
    n_chk++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_lh: err=%b rd=%h want 1/0", er, rd); end
`else
    n_chk++; if (er !== 1'b0 || rd !== 32'h00007FFF) begin n_fail++; $display("FAIL mis_lh: err=%b rd=%h want 0/00007fff", er, rd); end
`endif
  endtask

  task automatic test_hold_valid();
    logic [31:0] rd; logic er; int lat; int n0;
    n0 = acc_q.size();
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, er, lat);
    repeat (3) @(negedge clk);
    n_chk++; if (acc_q.size() - n0 !== 1) begin n_fail++; $display("FAIL hold_accepts: got %0d want 1", acc_q.size() - n0); end
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int n0; int bad;
    n0 = acc_q.size();
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    repeat (12) @(negedge clk);
    bus.req_valid = 1'b0;
    bad = 0;
    for (int i = n0 + 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 3) bad++;
    n_chk++; if (acc_q.size() - n0 !== 4 || bad !== 0) begin n_fail++; $display("FAIL b2b_lw: accepts=%0d bad_gaps=%0d want 4/0", acc_q.size() - n0, bad); end
    repeat (3) @(negedge clk);
    n0 = acc_q.size();
    bus.req_funct3 = 3'b111; bus.req_valid = 1'b1;
    repeat (12) @(negedge clk);
    bus.req_valid = 1'b0;
    bad = 0;
    for (int i = n0 + 1; i < acc_q.size(); i++) if (acc_q[i] - acc_q[i-1] != 2) bad++;
    n_chk++; if (acc_q.size() - n0 !== 6 || bad !== 0) begin n_fail++; $display("FAIL b2b_err: accepts=%0d bad_gaps=%0d want 6/0", acc_q.size() - n0, bad); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int t = 0; int rv = 0;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40;
    bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++; if (bus.mem_WE !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wr: mem_WE=%b want 1", bus.mem_WE); end
    reset = 1'b1;
    #1;
    n_chk++; if (bus.mem_WE !== 1'b0) begin n_fail++; $display("FAIL midrst_we_drop: mem_WE=%b want 0", bus.mem_WE); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: ready=%b resp_valid=%b want 1/0", bus.req_ready, bus.resp_valid); end
    while (t < 4) begin if (bus.resp_valid) rv++; @(negedge clk); t++; end
    n_chk++; if (rv !== 0) begin n_fail++; $display("FAIL midrst_noresp: responses=%0d want 0", rv); end
    n_chk++; if (mem[16] !== ref_mem[16]) begin n_fail++; $display("FAIL midrst_mem: got %h want %h", mem[16], ref_mem[16]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, rd_e, w_e; logic er, er_e, we; logic [2:0] f3; int lat, lat_e, wi;
    for (int it = 0; it < 300; it++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 19))
        0:       a = 32'($urandom_range(3990, 4010));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 127));
      endcase
      er_e  = exp_err(we, f3, a);
      lat_e = exp_lat(we, f3, er_e);
      wi    = er_e ? 0 : int'(a[31:2]);
      rd_e  = (er_e || we) ? 32'h0 : exp_load(ref_mem[wi], f3, a);
      do_req(we, f3, a, wd, 1'b0, rd, er, lat);
      if (!er_e && we) ref_mem[wi] = exp_store(ref_mem[wi], f3, a, wd);
      n_chk++; if (er !== er_e || lat !== lat_e) begin n_fail++; $display("FAIL rnd%0d_ctl: err=%b lat=%0d want %b/%0d (we=%b f3=%0d a=%h)", it, er, lat, er_e, lat_e, we, f3, a); end
      n_chk++; if (rd !== rd_e) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h (f3=%0d a=%h)", it, rd, rd_e, f3, a); end
      if (!er_e) begin
        w_e = ref_mem[wi];
        n_chk++; if (mem[wi] !== w_e) begin n_fail++; $display("FAIL rnd%0d_mem: word %0d got %h want %h", it, wi, mem[wi], w_e); end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < W; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_sw_lw();
    test_sub_word();
    test_half();
    test_errors();
    test_misalign();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
